// File: rtl/hilo_multiplier_pkg.sv
// Shared definitions for the HI/LO multiplier and the multiply-control decoder.
package hilo_multiplier_pkg;

    localparam int unsigned MULT_WIDTH  = 32;
    localparam int unsigned MULT_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // AluMux read-select codes; 2'b11 is treated like HILO_NONE.
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b01;
    localparam logic [1:0] HILO_LO   = 2'b10;

endpackage

// File: rtl/hilo_multiplier_if.sv
// Decoder-to-multiplier bus: MULT issue, HI/LO read select, operands and results.
interface hilo_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic             HiLoEnable;
    logic [1:0]       AluMux;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic [WIDTH-1:0] HiLoOut;
    logic             Busy;
    logic             Stall;

    modport master (
        output HiLoEnable, AluMux, A, B,
        input  Hi, Lo, HiLoOut, Busy, Stall
    );

    modport slave (
        input  HiLoEnable, AluMux, A, B,
        output Hi, Lo, HiLoOut, Busy, Stall
    );
endinterface

// File: rtl/hilo_mult_datapath.sv
// Unsigned shift-add datapath on operand magnitudes, with the sign reapplied on the way out.
module hilo_mult_datapath
    import hilo_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product_c
);
    localparam int unsigned W2 = 2 * WIDTH;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // The most negative value maps onto its own unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Upper half accumulates partial sums; lower half holds the multiplier being shifted out.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        addend  = acc_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend};
        if (load) begin
            mcand_d = magnitude(a);
            acc_d   = {{WIDTH{1'b0}}, magnitude(b)};
            sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
        end else if (step) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
        end
    end

    assign product_c = sign_q ? (~acc_q + W2'(1)) : acc_q;

endmodule

// File: rtl/hilo_multiplier.sv
// Iterative signed multiplier with HI/LO registers, MFHI/MFLO read mux and pipeline stall.
module hilo_multiplier
    import hilo_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH  = MULT_WIDTH,
    parameter int unsigned CYCLES = MULT_CYCLES
) (
    input logic              Clk,
    input logic              Reset,
    hilo_multiplier_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               load_c;
    logic               step_c;
    logic [2*WIDTH-1:0] product_c;

    hilo_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (Clk),
        .rst       (Reset),
        .load      (load_c),
        .step      (step_c),
        .a         (bus.A),
        .b         (bus.B),
        .product_c (product_c)
    );

    // Sequencer: accept in IDLE, one iteration per RUN cycle, commit HI/LO in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.HiLoEnable) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                {hi_d, lo_d} = product_c;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Reads while busy return the old value; Stall keeps the pipeline from committing it.
    always_comb begin
        case (bus.AluMux)
            HILO_HI: bus.HiLoOut = hi_q;
            HILO_LO: bus.HiLoOut = lo_q;
            default: bus.HiLoOut = '0;
        endcase
    end

    assign bus.Stall = busy_q & (bus.HiLoEnable | (bus.AluMux == HILO_HI) | (bus.AluMux == HILO_LO));
    assign bus.Hi    = hi_q;
    assign bus.Lo    = lo_q;
    assign bus.Busy  = busy_q;

endmodule
